hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 29 ++
 rtl/hazard_scoreboard_if.sv | 66 ++++++
 rtl/hazard_src_match.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants, forward-select type and source-match helper for the hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int CSR_ADDR_W = 12;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_t;

    // MEM wins over WB because it holds the younger value of the register.
    function automatic fwd_sel_t fwd_pick(
        input logic                 used,
        input logic [REG_IDX_W-1:0] rs,
        input logic                 mem_ok,
        input logic [REG_IDX_W-1:0] mem_rd,
        input logic                 wb_ok,
        input logic [REG_IDX_W-1:0] wb_rd
    );
        if (!used || rs == '0) return FWD_NONE;
        if (mem_ok && rs == mem_rd) return FWD_MEM;
        if (wb_ok && rs == wb_rd) return FWD_WB;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side bundle of the hazard scoreboard; CSR forwarding signals exist only
// when HAZARD_CSR_FWD_EN is defined.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int MAX_LD = 4
);
    localparam int LDW = $clog2(MAX_LD) + 1;

    logic [NSRC*REG_IDX_W-1:0] id_rs;
    logic [NSRC-1:0]           id_rs_use;
    logic [NSRC-1:0]           id_bju_use;
    logic [NSRC*REG_IDX_W-1:0] ex_rs;
    logic [NSRC-1:0]           ex_rs_use;
    logic                      ex_rd_w_en;
    logic [REG_IDX_W-1:0]      ex_rd;
    logic                      ex_load;
    logic                      ex_fire;
    logic                      mem_rd_w_en;
    logic [REG_IDX_W-1:0]      mem_rd;
    logic                      mem_lsu_r_valid;
    logic                      wb_rd_w_en;
    logic [REG_IDX_W-1:0]      wb_rd;
    logic [NSRC-1:0]           ex_fwd_mem;
    logic [NSRC-1:0]           ex_fwd_wb;
    logic [NSRC-1:0]           id_fwd_mem;
    logic [NSRC-1:0]           id_fwd_wb;
    logic                      if_id_stall;
    logic                      ex_ld_stall;
    logic [LDW-1:0]            ld_cnt;
`ifdef HAZARD_CSR_FWD_EN
    logic                      ex_csr_use;
    logic [CSR_ADDR_W-1:0]     ex_csr_addr;
    logic                      mem_csr_w_en;
    logic [CSR_ADDR_W-1:0]     mem_csr_addr;
    logic                      ex_fwd_mem_csr;
`endif

    // Handshake: ex_fire advances the EX instruction (a load issues only if ex_ld_stall
    // is low); mem_lsu_r_valid marks the single cycle in which load data for mem_rd lands.
    modport master (
`ifdef HAZARD_CSR_FWD_EN
        output ex_csr_use, ex_csr_addr, mem_csr_w_en, mem_csr_addr,
        input  ex_fwd_mem_csr,
`endif
        output id_rs, id_rs_use, id_bju_use, ex_rs, ex_rs_use,
        output ex_rd_w_en, ex_rd, ex_load, ex_fire,
        output mem_rd_w_en, mem_rd, mem_lsu_r_valid, wb_rd_w_en, wb_rd,
        input  ex_fwd_mem, ex_fwd_wb, id_fwd_mem, id_fwd_wb,
        input  if_id_stall, ex_ld_stall, ld_cnt
    );

    modport slave (
`ifdef HAZARD_CSR_FWD_EN
        input  ex_csr_use, ex_csr_addr, mem_csr_w_en, mem_csr_addr,
        output ex_fwd_mem_csr,
`endif
        input  id_rs, id_rs_use, id_bju_use, ex_rs, ex_rs_use,
        input  ex_rd_w_en, ex_rd, ex_load, ex_fire,
        input  mem_rd_w_en, mem_rd, mem_lsu_r_valid, wb_rd_w_en, wb_rd,
        output ex_fwd_mem, ex_fwd_wb, id_fwd_mem, id_fwd_wb,
        output if_id_stall, ex_ld_stall, ld_cnt
    );

endinterface

// File: rtl/hazard_src_match.sv
// Match, forward and stall terms for one source operand (both EX-stage and ID-stage readers).
module hazard_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
)(
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic                 id_rs_use,
    input  logic                 id_bju_use,
    input  logic [REG_IDX_W-1:0] ex_rs,
    input  logic                 ex_rs_use,
    input  logic [CNT_W-1:0]     id_pend,
    input  logic                 ex_rd_w_en,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_load,
    input  logic                 mem_ok,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 ret,
    input  logic                 wb_rd_w_en,
    input  logic [REG_IDX_W-1:0] wb_rd,
    output fwd_sel_t             ex_sel,
    output fwd_sel_t             id_sel,
    output logic                 stall
);
    logic id_used;
    logic ex_hit;
    logic pend_busy;

    assign id_used = (id_rs_use | id_bju_use) & (id_rs != '0);
    assign ex_hit  = ex_rd_w_en & (id_rs == ex_rd);

    // The last outstanding load returning this cycle is caught by the MEM forward path.
    assign pend_busy = (id_pend != '0) &
                       ~((id_pend == CNT_W'(1)) & ret & (mem_rd == id_rs));

    assign stall = id_used & (pend_busy | (ex_hit & ex_load) | (ex_hit & id_bju_use));

    assign ex_sel = fwd_pick(ex_rs_use, ex_rs, mem_ok, mem_rd, wb_rd_w_en, wb_rd);
    assign id_sel = fwd_pick(id_bju_use, id_rs, mem_ok, mem_rd, wb_rd_w_en, wb_rd);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register pending-load counters, forwarding selects and
// stalls. Optional CSR MEM->EX forwarding under HAZARD_CSR_FWD_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSRC   = 2,
    parameter int MAX_LD = 4,
    parameter int CNT_W  = 2
)(
    input  logic              clk,
    input  logic              rst,
    hazard_scoreboard_if.slave bus
);
    localparam int             LDW     = $clog2(MAX_LD) + 1;
    localparam logic [LDW-1:0] LD_FULL = LDW'(MAX_LD);

    logic [CNT_W-1:0]    pend [NUM_REGS];
    logic [LDW-1:0]      ld_cnt_q;
    logic                ld_full;
    logic                ld_stall;
    logic                issue;
    logic                ret;
    logic                mem_ok;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NSRC-1:0]     src_stall;
    fwd_sel_t            ex_sel [NSRC];
    fwd_sel_t            id_sel [NSRC];

    assign ld_full  = (ld_cnt_q == LD_FULL);
    assign ld_stall = bus.ex_load & ((pend[bus.ex_rd] == '1) | ld_full);
    assign issue    = bus.ex_fire & bus.ex_load & bus.ex_rd_w_en & (bus.ex_rd != '0) & ~ld_stall;
    assign ret      = bus.mem_lsu_r_valid & bus.mem_rd_w_en & (bus.mem_rd != '0);

    // An in-flight load to mem_rd has no data to forward until its return cycle.
    assign mem_ok = bus.mem_rd_w_en & ((pend[bus.mem_rd] == '0) | bus.mem_lsu_r_valid);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (issue) inc_vec[bus.ex_rd] = 1'b1;
        if (ret)   dec_vec[bus.mem_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
            ld_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    pend[r] <= pend[r] + 1'b1;
                else if (dec_vec[r] && !inc_vec[r] && pend[r] != '0)
                    pend[r] <= pend[r] - 1'b1;
            end
            if (issue && !ret && !ld_full)
                ld_cnt_q <= ld_cnt_q + 1'b1;
            else if (ret && !issue && ld_cnt_q != '0)
                ld_cnt_q <= ld_cnt_q - 1'b1;
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        hazard_src_match #(.CNT_W(CNT_W)) u_match (
            .id_rs      (bus.id_rs[REG_IDX_W*i +: REG_IDX_W]),
            .id_rs_use  (bus.id_rs_use[i]),
            .id_bju_use (bus.id_bju_use[i]),
            .ex_rs      (bus.ex_rs[REG_IDX_W*i +: REG_IDX_W]),
            .ex_rs_use  (bus.ex_rs_use[i]),
            .id_pend    (pend[bus.id_rs[REG_IDX_W*i +: REG_IDX_W]]),
            .ex_rd_w_en (bus.ex_rd_w_en),
            .ex_rd      (bus.ex_rd),
            .ex_load    (bus.ex_load),
            .mem_ok     (mem_ok),
            .mem_rd     (bus.mem_rd),
            .ret        (ret),
            .wb_rd_w_en (bus.wb_rd_w_en),
            .wb_rd      (bus.wb_rd),
            .ex_sel     (ex_sel[i]),
            .id_sel     (id_sel[i]),
            .stall      (src_stall[i])
        );
        assign bus.ex_fwd_mem[i] = (ex_sel[i] == FWD_MEM);
        assign bus.ex_fwd_wb[i]  = (ex_sel[i] == FWD_WB);
        assign bus.id_fwd_mem[i] = (id_sel[i] == FWD_MEM);
        assign bus.id_fwd_wb[i]  = (id_sel[i] == FWD_WB);
    end

    assign bus.if_id_stall = |src_stall;
    assign bus.ex_ld_stall = ld_stall;
    // Count reads as zero while reset is held, not only after the clearing edge.
    assign bus.ld_cnt      = rst ? '0 : ld_cnt_q;

`ifdef HAZARD_CSR_FWD_EN
    assign bus.ex_fwd_mem_csr = bus.ex_csr_use & bus.mem_csr_w_en &
                                (bus.ex_csr_addr == bus.mem_csr_addr);
`else
    // CSR reads take the architectural value; no CSR bypass path.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with an expected-value queue and a negedge monitor.
module tb_hazard_scoreboard;
    localparam int NSRC   = 2;
    localparam int MAX_LD = 4;
    localparam int CNT_W  = 2;
    localparam int LDW    = 3;
    localparam int EXP_W  = 4*NSRC + 2 + LDW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NSRC(NSRC), .MAX_LD(MAX_LD)) bus ();

    hazard_scoreboard #(.NSRC(NSRC), .MAX_LD(MAX_LD), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [EXP_W-1:0] exp_q[$];
    string            name_q[$];
    int               tests = 0;
    int               fails = 0;

    wire [EXP_W-1:0] obs = {bus.ex_fwd_mem, bus.ex_fwd_wb, bus.id_fwd_mem, bus.id_fwd_wb,
                            bus.if_id_stall, bus.ex_ld_stall, bus.ld_cnt};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EXP_W-1:0] e;
            string            n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL %s: got %b expected %b (efm efw ifm ifw st ls cnt)", n, obs, e);
            end
        end
    end

    task automatic idle();
        rst                 = 1'b0;
        bus.id_rs           = '0;
        bus.id_rs_use       = '0;
        bus.id_bju_use      = '0;
        bus.ex_rs           = '0;
        bus.ex_rs_use       = '0;
        bus.ex_rd_w_en      = 1'b0;
        bus.ex_rd           = '0;
        bus.ex_load         = 1'b0;
        bus.ex_fire         = 1'b0;
        bus.mem_rd_w_en     = 1'b0;
        bus.mem_rd          = '0;
        bus.mem_lsu_r_valid = 1'b0;
        bus.wb_rd_w_en      = 1'b0;
        bus.wb_rd           = '0;
`ifdef HAZARD_CSR_FWD_EN
        bus.ex_csr_use      = 1'b0;
        bus.ex_csr_addr     = '0;
        bus.mem_csr_w_en    = 1'b0;
        bus.mem_csr_addr    = '0;
`endif
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input string n, input logic [1:0] efm, input logic [1:0] efw,
                              input logic [1:0] ifm, input logic [1:0] ifw,
                              input logic st, input logic ls, input logic [LDW-1:0] lc);
        exp_q.push_back({efm, efw, ifm, ifw, st, ls, lc});
        name_q.push_back(n);
    endtask

    task automatic issue_ld(input logic [4:0] rd);
        bus.ex_load    = 1'b1;
        bus.ex_fire    = 1'b1;
        bus.ex_rd_w_en = 1'b1;
        bus.ex_rd      = rd;
    endtask

    task automatic ret_ld(input logic [4:0] rd);
        bus.mem_rd_w_en     = 1'b1;
        bus.mem_rd          = rd;
        bus.mem_lsu_r_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;

        next_cycle(); rst = 1'b1;
        expect_out("reset_idle", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd0);
        next_cycle(); rst = 1'b1; issue_ld(5'd3);
        expect_out("reset_vs_issue", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd0);

        // add x5 in MEM, sub reads x5 in EX; x3 must be clean after reset beat the issue
        next_cycle();
        bus.mem_rd_w_en = 1'b1; bus.mem_rd = 5'd5;
        bus.ex_rs = {5'd6, 5'd5}; bus.ex_rs_use = 2'b11;
        bus.id_rs = {5'd3, 5'd0}; bus.id_rs_use = 2'b10;
        expect_out("ex_fwd_mem", 2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 3'd0);

        next_cycle();
        bus.mem_rd_w_en = 1'b1; bus.mem_rd = 5'd5;
        bus.wb_rd_w_en = 1'b1; bus.wb_rd = 5'd5;
        bus.ex_rs = {5'd5, 5'd5}; bus.ex_rs_use = 2'b11;
        expect_out("mem_over_wb", 2'b11, 2'b00, 2'b00, 2'b00, 0, 0, 3'd0);

        next_cycle();
        bus.mem_rd_w_en = 1'b1; bus.mem_rd = 5'd0;
        bus.wb_rd_w_en = 1'b1; bus.wb_rd = 5'd6;
        bus.ex_rs = {5'd6, 5'd0}; bus.ex_rs_use = 2'b11;
        expect_out("wb_fwd_x0_never", 2'b00, 2'b10, 2'b00, 2'b00, 0, 0, 3'd0);

        next_cycle();
        bus.mem_rd_w_en = 1'b1; bus.mem_rd = 5'd9;
        bus.wb_rd_w_en = 1'b1; bus.wb_rd = 5'd10;
        bus.id_rs = {5'd10, 5'd9}; bus.id_bju_use = 2'b11;
        expect_out("id_fwd", 2'b00, 2'b00, 2'b01, 2'b10, 0, 0, 3'd0);

        next_cycle();
        bus.id_rs = {5'd0, 5'd4}; bus.id_bju_use = 2'b01;
        bus.ex_rd_w_en = 1'b1; bus.ex_rd = 5'd4; bus.ex_fire = 1'b1;
        expect_out("bju_on_ex_alu", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 3'd0);

        next_cycle();
        bus.id_rs = {5'd0, 5'd4}; bus.id_rs_use = 2'b01;
        bus.ex_rd_w_en = 1'b1; bus.ex_rd = 5'd4;
        expect_out("alu_on_ex_alu", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd0);

        // lw x7 then beq x7,x0 waits for the return cycle
        next_cycle(); issue_ld(5'd7);
        bus.id_rs = {5'd0, 5'd7}; bus.id_bju_use = 2'b11;
        expect_out("beq_on_ex_load", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 3'd0);
        next_cycle();
        bus.mem_rd_w_en = 1'b1; bus.mem_rd = 5'd7;
        bus.id_rs = {5'd0, 5'd7}; bus.id_bju_use = 2'b11;
        expect_out("beq_wait_mem", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 3'd1);
        next_cycle(); ret_ld(5'd7);
        bus.id_rs = {5'd0, 5'd7}; bus.id_bju_use = 2'b11;
        expect_out("beq_return", 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 3'd1);

        // two loads to x7, one return leaves pend[7]=1
        next_cycle(); issue_ld(5'd7);
        expect_out("lw7_a", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd0);
        next_cycle(); issue_ld(5'd7);
        bus.id_rs = {5'd0, 5'd7}; bus.id_rs_use = 2'b01;
        expect_out("lw7_b", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 3'd1);
        next_cycle(); ret_ld(5'd7);
        bus.id_rs = {5'd0, 5'd7}; bus.id_rs_use = 2'b01;
        expect_out("pend2_ret", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 3'd2);
        next_cycle();
        bus.id_rs = {5'd0, 5'd7}; bus.id_rs_use = 2'b01;
        expect_out("pend1_stall", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 3'd1);
        next_cycle(); ret_ld(5'd7);
        bus.id_rs = {5'd0, 5'd7}; bus.id_rs_use = 2'b01;
        expect_out("pend1_ret_nostall", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd1);

        // fill all load slots, fifth load stalls
        for (int k = 0; k < 4; k++) begin
            next_cycle(); issue_ld(5'(k + 1));
            expect_out("fill", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'(k));
        end
        next_cycle();
        bus.ex_load = 1'b1; bus.ex_rd_w_en = 1'b1; bus.ex_rd = 5'd5;
        expect_out("ld_full_stall", 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 3'd4);
        next_cycle(); ret_ld(5'd4);
        expect_out("ret_from_full", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd4);

        // reset with three loads in flight, then a stray return
        next_cycle(); rst = 1'b1; ret_ld(5'd1);
        expect_out("reset_mid", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd0);
        next_cycle();
        expect_out("after_reset", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd0);
        next_cycle(); ret_ld(5'd2);
        bus.id_rs = {5'd0, 5'd2}; bus.id_bju_use = 2'b01;
        expect_out("stray_return", 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 3'd0);
        next_cycle();
        bus.id_rs = {5'd0, 5'd2}; bus.id_rs_use = 2'b01;
        expect_out("stray_pend_zero", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd0);

        // pend counter saturation at all-ones
        for (int k = 0; k < 3; k++) begin
            next_cycle(); issue_ld(5'd9);
            expect_out("lw9", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'(k));
        end
        next_cycle();
        bus.ex_load = 1'b1; bus.ex_rd_w_en = 1'b1; bus.ex_rd = 5'd9;
        expect_out("pend_sat_stall", 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 3'd3);

        // simultaneous issue and return on x11 cancel
        next_cycle(); issue_ld(5'd11); ret_ld(5'd11);
        expect_out("inc_dec_same", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd3);
        next_cycle();
        bus.id_rs = {5'd0, 5'd11}; bus.id_rs_use = 2'b01;
        expect_out("inc_dec_pend0", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd3);
        next_cycle(); ret_ld(5'd9);
        bus.id_rs = {5'd0, 5'd9}; bus.id_rs_use = 2'b01;
        expect_out("pend3_ret", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 3'd3);
        next_cycle();
        bus.ex_load = 1'b1; bus.ex_rd_w_en = 1'b1; bus.ex_rd = 5'd9;
        expect_out("pend2_no_stall", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 3'd2);

        next_cycle();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, 0 required", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
